// File: rtl/conv_coef_fetch_pkg.sv
// Shared constants, fetch FSM encoding and address helper for the coefficient fetch stage.
package conv_pkg;
  localparam int ADDR_W     = 6;
  localparam int ROM_DEPTH  = 64;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  // ROM addresses wrap around the 64-entry space.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] off);
    return ADDR_W'((int'(base) + int'(off)) % ROM_DEPTH);
  endfunction
endpackage

// File: rtl/conv_coef_fetch_if.sv
// Coefficient stream towards the MAC datapath: valid/ready plus index and last tag.
interface conv_coef_fetch_if #(parameter int DATA_W = 8);
  import conv_pkg::*;
  logic [DATA_W-1:0] coef_data;
  logic              coef_valid;
  logic              coef_ready;
  logic              coef_last;
  logic [ADDR_W-1:0] coef_idx;

  modport master (output coef_data, coef_valid, coef_last, coef_idx, input coef_ready);
  modport slave  (input coef_data, coef_valid, coef_last, coef_idx, output coef_ready);
endinterface

// File: rtl/conv_coef_fetch_fifo.sv
// Synchronous FIFO with a combinational head; the head reads 0 while empty.
module coef_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/conv_coef_fetch.sv
// Kernel fetch: issues NUM_COEF ROM reads from base_addr, tracks ROM latency,
// buffers returned words and streams them out over valid/ready.
module conv_coef_fetch
  import conv_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_COEF   = 9,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  conv_coef_fetch_if.master  coef
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW  = 1 + ADDR_W + DATA_W;

  fetch_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]             base_q;
  logic [CNT_W-1:0]              issue_cnt;
  logic [CNT_W-1:0]              inflight;
  logic                          issue, credit_ok;
  logic [ADDR_W-1:0]             issue_idx, next_addr;
  // vld_pipe[0] is aligned with rom_addr; vld_pipe[ROM_LAT] lines up with rom_data.
  logic [ROM_LAT:0]              vld_pipe;
  logic [ROM_LAT:0][ADDR_W-1:0]  idx_pipe;

  logic [EW-1:0]                 fifo_din, fifo_dout;
  logic                          fifo_full, fifo_empty, pop;
  logic [FCW-1:0]                fifo_cnt;
  logic                          head_last;
  logic [ADDR_W-1:0]             head_idx;
  logic [DATA_W-1:0]             head_data;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ROM_LAT; i++) inflight += CNT_W'(vld_pipe[i]);
  end

  assign credit_ok = !fifo_full && ((inflight + CNT_W'(fifo_cnt)) < CNT_W'(FIFO_DEPTH));

  // The first address goes out on the accepting edge so rom_addr=base one cycle after start.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    issue_idx = issue_cnt[ADDR_W-1:0];
    next_addr = wrap_addr(base_q, issue_cnt[ADDR_W-1:0]);
    case (state_q)
      IDLE: begin
        if (start) begin
          issue     = 1'b1;
          issue_idx = '0;
          next_addr = base_addr;
          state_d   = (NUM_COEF == 1) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if ((issue_cnt < CNT_W'(NUM_COEF)) && credit_ok) begin
          issue = 1'b1;
          if (issue_cnt == CNT_W'(NUM_COEF - 1)) state_d = DRAIN;
        end
      end
      DRAIN: if (pop && head_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      issue_cnt <= '0;
      rom_addr  <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
    end else begin
      state_q  <= state_d;
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], issue};
      idx_pipe <= {idx_pipe[ROM_LAT-1:0], issue_idx};
      if (state_q == IDLE && start) base_q <= base_addr;
      if (issue) begin
        rom_addr  <= next_addr;
        issue_cnt <= (state_q == IDLE) ? CNT_W'(1) : issue_cnt + CNT_W'(1);
      end
    end
  end

  assign fifo_din = {(idx_pipe[ROM_LAT] == ADDR_W'(NUM_COEF - 1)), idx_pipe[ROM_LAT], rom_data};
  assign pop      = coef.coef_valid && coef.coef_ready;

  coef_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .CW(FCW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[ROM_LAT]),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign {head_last, head_idx, head_data} = fifo_dout;

  assign coef.coef_valid = !fifo_empty;
  assign coef.coef_data  = head_data;
  assign coef.coef_idx   = head_idx;
  assign coef.coef_last  = head_last;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
endmodule
